// File: rtl/decode_hazard_scoreboard.sv
// Decode-side hazard scoreboard: tracks in-flight destinations across the
// post-decode stages and drives forward selects, stall and long-op hold.
module decode_hazard_scoreboard #(
    parameter int NREAD    = 3,
    parameter int NSTAGE   = 3,
    parameter int LONG_LAT = 32,
    parameter int RW       = 6,
    localparam int SW = $clog2(NSTAGE + 1),
    localparam int CW = (LONG_LAT > 1) ? $clog2(LONG_LAT) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                advance,
    input  logic                id_valid,
    input  logic [NREAD*RW-1:0] id_src,
    input  logic [NREAD-1:0]    id_src_en,
    input  logic [RW-1:0]       id_dst,
    input  logic [SW-1:0]       id_dst_rdy,
    input  logic                id_long,
    input  logic [NSTAGE-1:0]   flush_mask,
    output logic                stall,
    output logic [NREAD*SW-1:0] fwd_sel,
    output logic                ex_hold
);

    typedef struct packed {
        logic          v;
        logic [RW-1:0] dst;
        logic [SW-1:0] rdy;
    } slot_t;

    typedef enum logic {IDLE, BUSY} state_t;

    slot_t [NSTAGE-1:0] slot_q, slot_d;
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic          hazard;
    logic          issue;
    logic          move;
    logic [SW-1:0] rdy_n;
    logic [RW-1:0] src;
    logic          hit;
    logic [SW-1:0] hit_s;
    logic [SW-1:0] hit_rdy;

    assign ex_hold = (state_q == BUSY);
    assign stall   = id_valid && (hazard || ex_hold);
    assign issue   = id_valid && !stall;
    assign move    = advance && !ex_hold;

    // Scanning oldest to youngest lets the youngest producer overwrite.
    always_comb begin
        hazard  = 1'b0;
        fwd_sel = '0;
        src     = '0;
        hit     = 1'b0;
        hit_s   = '0;
        hit_rdy = '0;
        for (int i = 0; i < NREAD; i++) begin
            src     = id_src[i*RW +: RW];
            hit     = 1'b0;
            hit_s   = '0;
            hit_rdy = '0;
            for (int s = NSTAGE; s >= 1; s--) begin
                if (slot_q[s-1].v && slot_q[s-1].dst == src) begin
                    hit     = 1'b1;
                    hit_s   = SW'(s);
                    hit_rdy = slot_q[s-1].rdy;
                end
            end
            if (id_src_en[i] && src != '0 && hit) begin
                if (hit_s >= hit_rdy) begin
                    fwd_sel[i*SW +: SW] = hit_s;
                end else begin
                    hazard = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rdy_n = id_dst_rdy;
        if (id_dst_rdy == '0) begin
            rdy_n = SW'(1);
        end else if (id_dst_rdy > SW'(NSTAGE)) begin
            rdy_n = SW'(NSTAGE);
        end
    end

    // Flush is applied after the shift so it always hits the post-edge slot.
    always_comb begin
        slot_d = slot_q;
        if (move) begin
            for (int s = NSTAGE - 1; s >= 1; s--) begin
                slot_d[s] = slot_q[s-1];
            end
            slot_d[0].v   = issue && (id_dst != '0);
            slot_d[0].dst = id_dst;
            slot_d[0].rdy = rdy_n;
        end
        for (int s = 0; s < NSTAGE; s++) begin
            if (flush_mask[s]) begin
                slot_d[s].v = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (move && issue && id_long && !flush_mask[0]) begin
                    state_d = BUSY;
                    cnt_d   = CW'(LONG_LAT - 1);
                end
            end
            BUSY: begin
                if (flush_mask[0] || cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            slot_q  <= slot_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// Bench for decode_hazard_scoreboard: directed vector table, reset corner
// sequence, and random traffic against an in-flight list model.
module tb_decode_hazard_scoreboard;

    localparam int NR  = 3;
    localparam int NS  = 3;
    localparam int LAT = 4;
    localparam int RW  = 6;
    localparam int SW  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              advance;
    logic              id_valid;
    logic [NR*RW-1:0]  id_src;
    logic [NR-1:0]     id_src_en;
    logic [RW-1:0]     id_dst;
    logic [SW-1:0]     id_dst_rdy;
    logic              id_long;
    logic [NS-1:0]     flush_mask;
    logic              stall;
    logic [NR*SW-1:0]  fwd_sel;
    logic              ex_hold;

    decode_hazard_scoreboard #(
        .NREAD(NR), .NSTAGE(NS), .LONG_LAT(LAT), .RW(RW)
    ) dut (
        .clk(clk), .reset(reset), .advance(advance),
        .id_valid(id_valid), .id_src(id_src),
        .id_src_en(id_src_en), .id_dst(id_dst),
        .id_dst_rdy(id_dst_rdy), .id_long(id_long),
        .flush_mask(flush_mask), .stall(stall),
        .fwd_sel(fwd_sel), .ex_hold(ex_hold)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       adv, vld;
        logic [5:0] s0, s1, s2;
        logic [2:0] en;
        logic [5:0] dst;
        logic [1:0] rdy;
        logic       lng;
        logic [2:0] fl;
        int         e_st, e_f0, e_f1, e_f2, e_h;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        int adv, int vld, int s0, int s1, int s2, int en,
        int dst, int rdy, int lng, int fl,
        int st, int f0, int f1, int f2, int h);
        vec_t r;
        r.adv = 1'(adv); r.vld = 1'(vld);
        r.s0 = 6'(s0); r.s1 = 6'(s1); r.s2 = 6'(s2);
        r.en = 3'(en); r.dst = 6'(dst); r.rdy = 2'(rdy);
        r.lng = 1'(lng); r.fl = 3'(fl);
        r.e_st = st; r.e_f0 = f0; r.e_f1 = f1; r.e_f2 = f2;
        r.e_h = h;
        return r;
    endfunction

    // Model: list of in-flight producers, each with its current stage.
    typedef struct { int dst; int rdy; int st; } inflt_t;
    inflt_t fq[$];
    int     hold_left = 0;
    int     m_fwd[NR];
    int     m_stall;
    int     m_hold;

    task automatic model_reset();
        fq.delete();
        hold_left = 0;
    endtask

    task automatic model_eval();
        int src, best, brdy, hz;
        hz = 0;
        m_hold = (hold_left > 0) ? 1 : 0;
        for (int i = 0; i < NR; i++) begin
            m_fwd[i] = 0;
            src = int'(id_src[i*RW +: RW]);
            if (id_src_en[i] && src != 0) begin
                best = 0;
                brdy = 0;
                foreach (fq[k]) begin
                    if (fq[k].dst == src && (best == 0 || fq[k].st < best)) begin
                        best = fq[k].st;
                        brdy = fq[k].rdy;
                    end
                end
                if (best != 0) begin
                    if (best >= brdy) m_fwd[i] = best;
                    else hz = 1;
                end
            end
        end
        m_stall = (id_valid && (hz != 0 || m_hold != 0)) ? 1 : 0;
    endtask

    task automatic model_update();
        inflt_t nq[$];
        inflt_t e;
        int     mv, iss, r;
        mv  = (advance && hold_left == 0) ? 1 : 0;
        iss = (id_valid && m_stall == 0) ? 1 : 0;
        foreach (fq[k]) begin
            e = fq[k];
            if (mv != 0) e.st = e.st + 1;
            if (e.st <= NS && !flush_mask[e.st-1]) nq.push_back(e);
        end
        r = int'(id_dst_rdy);
        if (r == 0) r = 1;
        if (r > NS) r = NS;
        if (mv != 0 && iss != 0 && id_dst != 0 && !flush_mask[0]) begin
            e.dst = int'(id_dst);
            e.rdy = r;
            e.st  = 1;
            nq.push_back(e);
        end
        fq = nq;
        if (hold_left > 0) begin
            hold_left = flush_mask[0] ? 0 : hold_left - 1;
        end else if (mv != 0 && iss != 0 && id_long && !flush_mask[0]) begin
            hold_left = LAT;
        end
    endtask

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(string tag, int st, int f0, int f1,
                              int f2, int h);
        chk({tag, ".stall"}, int'(stall), st);
        chk({tag, ".fwd0"}, int'(fwd_sel[1:0]), f0);
        chk({tag, ".fwd1"}, int'(fwd_sel[3:2]), f1);
        chk({tag, ".fwd2"}, int'(fwd_sel[5:4]), f2);
        chk({tag, ".hold"}, int'(ex_hold), h);
    endtask

    task automatic apply(vec_t v);
        advance    = v.adv;
        id_valid   = v.vld;
        id_src     = {v.s2, v.s1, v.s0};
        id_src_en  = v.en;
        id_dst     = v.dst;
        id_dst_rdy = v.rdy;
        id_long    = v.lng;
        flush_mask = v.fl;
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    int regs[6] = '{0, 1, 2, 3, 32, 33};

    initial begin
        vec_t v;
        reset = 1'b1;
        apply(mk(0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0));
        repeat (2) @(negedge clk);
        check_outs("rst", 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        check_outs("rst_rel", 0, 0, 0, 0, 0);
        edge_step();

        // adv vld s0 s1 s2 en dst rdy lng fl | stall f0 f1 f2 hold
        tbl.push_back(mk(1,1, 0,0,0,0, 5,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1, 5,0,0,1, 0,1,0,0, 0,1,0,0,0));
        tbl.push_back(mk(1,1, 5,0,0,1, 0,1,0,0, 0,2,0,0,0));
        tbl.push_back(mk(1,1, 5,0,0,1, 0,1,0,0, 0,3,0,0,0));
        tbl.push_back(mk(1,1, 5,0,0,1, 0,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1, 0,0,0,0, 8,2,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1, 0,8,0,2, 0,1,0,0, 1,0,0,0,0));
        tbl.push_back(mk(1,1, 0,8,0,2, 0,1,0,0, 0,0,2,0,0));
        tbl.push_back(mk(1,1, 0,8,0,2, 0,1,0,0, 0,0,3,0,0));
        tbl.push_back(mk(1,1, 0,0,0,0, 32,1,1,0, 0,0,0,0,0));
        for (int k = 0; k < LAT; k++)
            tbl.push_back(mk(1,1, 32,0,0,1, 9,1,0,0, 1,1,0,0,1));
        tbl.push_back(mk(1,1, 32,0,0,1, 9,1,0,0, 0,1,0,0,0));
        tbl.push_back(mk(1,0, 32,0,0,1, 0,1,0,0, 0,2,0,0,0));
        tbl.push_back(mk(1,0, 32,0,0,1, 0,1,0,0, 0,3,0,0,0));
        tbl.push_back(mk(1,0, 32,0,0,1, 0,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1, 0,0,0,0, 3,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1, 3,0,0,1, 3,1,0,0, 0,1,0,0,0));
        tbl.push_back(mk(0,0, 3,0,0,1, 0,1,0,1, 0,1,0,0,0));
        tbl.push_back(mk(1,0, 3,0,0,1, 0,1,0,0, 0,2,0,0,0));
        tbl.push_back(mk(1,0, 3,0,0,1, 0,1,0,0, 0,3,0,0,0));
        tbl.push_back(mk(1,1, 0,0,0,0, 7,1,0,1, 0,0,0,0,0));
        tbl.push_back(mk(1,1, 7,0,0,1, 0,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1, 0,0,0,1, 0,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1, 0,0,0,0, 12,3,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1, 12,0,12,0, 0,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1, 0,0,12,4, 0,1,0,0, 1,0,0,0,0));
        tbl.push_back(mk(1,1, 0,0,12,4, 0,1,0,0, 0,0,0,3,0));
        tbl.push_back(mk(1,1, 0,0,0,0, 12,3,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,0, 12,0,0,1, 0,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1, 12,0,0,1, 0,1,0,0, 1,0,0,0,0));
        tbl.push_back(mk(1,1, 12,0,0,1, 0,1,0,0, 0,3,0,0,0));
        tbl.push_back(mk(1,1, 0,0,0,0, 20,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1, 20,0,0,1, 0,1,0,0, 0,1,0,0,0));

        foreach (tbl[i]) begin
            apply(tbl[i]);
            #1;
            model_eval();
            check_outs($sformatf("vec%0d", i), tbl[i].e_st,
                       tbl[i].e_f0, tbl[i].e_f1, tbl[i].e_f2, tbl[i].e_h);
            edge_step();
        end

        // Fill all slots, enter the hold, then reset mid-cycle.
        apply(mk(1,1, 0,0,0,0, 1,1,0,0, 0,0,0,0,0));
        #1; model_eval(); edge_step();
        apply(mk(1,1, 0,0,0,0, 2,1,0,0, 0,0,0,0,0));
        #1; model_eval(); edge_step();
        apply(mk(1,1, 0,0,0,0, 33,1,1,0, 0,0,0,0,0));
        #1; model_eval(); edge_step();
        v = mk(1,1, 33,2,1,7, 0,1,0,0, 0,0,0,0,0);
        apply(v);
        #1; model_eval();
        check_outs("busy", 1, 1, 2, 3, 1);
        edge_step();
        apply(v);
        #2;
        reset = 1'b1;
        #1;
        check_outs("arst", 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        apply(mk(1,1, 33,2,1,7, 4,3,0,0, 0,0,0,0,0));
        #1; model_eval();
        check_outs("post_rst", 0, 0, 0, 0, 0);
        edge_step();

        for (int n = 0; n < 600; n++) begin
            advance    = ($urandom_range(0, 7) != 0);
            id_valid   = ($urandom_range(0, 5) != 0);
            for (int i = 0; i < NR; i++)
                id_src[i*RW +: RW] = 6'(regs[$urandom_range(0, 5)]);
            id_src_en  = 3'($urandom_range(0, 7));
            id_dst     = 6'(regs[$urandom_range(0, 5)]);
            id_dst_rdy = 2'($urandom_range(0, 3));
            id_long    = ($urandom_range(0, 15) == 0);
            flush_mask = ($urandom_range(0, 9) == 0)
                       ? 3'($urandom_range(1, 7)) : 3'b000;
            #1;
            model_eval();
            check_outs($sformatf("rnd%0d", n), m_stall,
                       m_fwd[0], m_fwd[1], m_fwd[2], m_hold);
            edge_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
